seg7_count_monitor: RTL and testbench

- Receiving end of the seven-segment bus: samples an active-low {a,b,c,d,e,f,g} pattern driven by a counter/decoder block and recovers the displayed digit.
- Filters glitches and confirms each digit is a legal successor of the previous one (mod WRAP_MAX+1 count sequence).
- Reports decoded digit, blank state, sticky pattern/sequence errors and a legal-step count.
- Used as an on-board checker for display-driving counters and as a bench monitor.

---
 rtl/seg7_pkg.sv | 50 +++++
 rtl/seg7_count_monitor_if.sv | 22 ++
 rtl/seg7_stable_filter.sv | 44 ++++
 rtl/seg7_count_monitor.sv | 88 ++++++++
 tb/tb_seg7_count_monitor.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment pattern constants, decode function and FSM states
package seg7_pkg;

    localparam logic [6:0] PAT_0     = 7'b0000001;
    localparam logic [6:0] PAT_1     = 7'b1001111;
    localparam logic [6:0] PAT_2     = 7'b0010010;
    localparam logic [6:0] PAT_3     = 7'b0000110;
    localparam logic [6:0] PAT_4     = 7'b1001100;
    localparam logic [6:0] PAT_5     = 7'b0100100;
    localparam logic [6:0] PAT_6     = 7'b0100000;
    localparam logic [6:0] PAT_7     = 7'b0001111;
    localparam logic [6:0] PAT_8     = 7'b0000000;
    localparam logic [6:0] PAT_9     = 7'b0000100;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        TRACK      = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] digit;
    } decode_t;

    function automatic decode_t seg7_decode(input logic [6:0] pat);
        decode_t d;
        d = '{valid: 1'b1, blank: 1'b0, digit: 4'd0};
        case (pat)
            PAT_0:     d.digit = 4'd0;
            PAT_1:     d.digit = 4'd1;
            PAT_2:     d.digit = 4'd2;
            PAT_3:     d.digit = 4'd3;
            PAT_4:     d.digit = 4'd4;
            PAT_5:     d.digit = 4'd5;
            PAT_6:     d.digit = 4'd6;
            PAT_7:     d.digit = 4'd7;
            PAT_8:     d.digit = 4'd8;
            PAT_9:     d.digit = 4'd9;
            PAT_BLANK: begin
                d.valid = 1'b0;
                d.blank = 1'b1;
            end
            default:   d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_count_monitor_if.sv
// rtl/seg7_count_monitor_if.sv - segment bus in, monitor results out
interface seg7_count_monitor_if #(
    parameter int CNT_W = 8
);
    logic             a, b, c, d, e, f, g;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             blank;
    logic             err_pattern;
    logic             err_sequence;
    logic [CNT_W-1:0] step_count;

    modport master (
        output a, b, c, d, e, f, g,
        input  digit, digit_valid, blank, err_pattern, err_sequence, step_count
    );

    modport slave (
        input  a, b, c, d, e, f, g,
        output digit, digit_valid, blank, err_pattern, err_sequence, step_count
    );
endinterface

// File: rtl/seg7_stable_filter.sv
// rtl/seg7_stable_filter.sv - 2-flop synchronizer and stability filter for the segment bus
module seg7_stable_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_seg,
    output logic [6:0] o_pattern,
    output logic       o_accept
);
    localparam int             CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(STABLE_CYCLES - 1);

    logic [6:0]    r_sync1, r_sync2, r_prev, r_acc;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    // Counter saturates at LAST; a held accepted pattern never re-accepts since it equals r_acc.
    always_comb begin
        w_cnt_next = '0;
        if (r_sync2 == r_prev)
            w_cnt_next = (r_cnt == LAST) ? r_cnt : r_cnt + 1'b1;
    end

    assign o_accept  = (w_cnt_next == LAST) && (r_sync2 != r_acc);
    assign o_pattern = r_sync2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 7'h7F;
            r_sync2 <= 7'h7F;
            r_prev  <= 7'h7F;
            r_acc   <= 7'h7F;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_seg;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_cnt   <= w_cnt_next;
            if (o_accept)
                r_acc <= r_sync2;
        end
    end
endmodule

// File: rtl/seg7_count_monitor.sv
// rtl/seg7_count_monitor.sv - recovers the displayed digit and checks the count sequence
module seg7_count_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int WRAP_MAX      = 7,
    parameter int CNT_W         = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  SW17,
    seg7_count_monitor_if.slave   bus
);
    logic [6:0]       w_seg, w_pattern;
    logic             w_accept;
    decode_t          w_dec;
    logic [3:0]       w_expected;
    logic             w_legal;
    state_t           r_state, w_state_next;
    logic [3:0]       r_digit;
    logic             r_valid, r_blank, r_err_pat, r_err_seq;
    logic [CNT_W-1:0] r_step;

    assign w_seg = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};

    seg7_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .i_clk     (CLOCK_50),
        .i_rst     (SW17),
        .i_seg     (w_seg),
        .o_pattern (w_pattern),
        .o_accept  (w_accept)
    );

    assign w_dec = seg7_decode(w_pattern);

    // A jump back to 0 is treated as a counter reset, not a sequence break.
    always_comb begin
        w_state_next = r_state;
        w_expected   = (r_digit == 4'(WRAP_MAX)) ? 4'd0 : r_digit + 4'd1;
        w_legal      = (w_dec.digit == w_expected) || (w_dec.digit == 4'd0);
        if (w_accept)
            w_state_next = w_dec.valid ? TRACK : WAIT_FIRST;
    end

    always_ff @(posedge CLOCK_50) begin
        if (SW17)
            r_state <= WAIT_FIRST;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge CLOCK_50) begin
        if (SW17) begin
            r_digit   <= 4'd0;
            r_valid   <= 1'b0;
            r_blank   <= 1'b1;
            r_err_pat <= 1'b0;
            r_err_seq <= 1'b0;
            r_step    <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                if (w_dec.valid) begin
                    r_digit <= w_dec.digit;
                    r_valid <= 1'b1;
                    r_blank <= 1'b0;
                    if (r_state == TRACK) begin
                        if (!w_legal)
                            r_err_seq <= 1'b1;
                        else if (r_step != {CNT_W{1'b1}})
                            r_step <= r_step + 1'b1;
                    end
                end else if (w_dec.blank) begin
                    r_blank <= 1'b1;
                end else begin
                    r_err_pat <= 1'b1;
                    r_blank   <= 1'b0;
                end
            end
        end
    end

    assign bus.digit        = r_digit;
    assign bus.digit_valid  = r_valid;
    assign bus.blank        = r_blank;
    assign bus.err_pattern  = r_err_pat;
    assign bus.err_sequence = r_err_seq;
    assign bus.step_count   = r_step;
endmodule

// File: tb/tb_seg7_count_monitor.sv
// tb/tb_seg7_count_monitor.sv - directed self-checking bench for seg7_count_monitor
module tb_seg7_count_monitor;
    localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                           P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100,
                           P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000,
                           PBL = 7'b1111111, PBAD = 7'b1110000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulses   = 0;
    int   base;

    seg7_count_monitor_if #(.CNT_W(8)) bus ();

    seg7_count_monitor #(.STABLE_CYCLES(4), .WRAP_MAX(7), .CNT_W(8)) dut (
        .CLOCK_50 (clk),
        .SW17     (rst),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    always @(negedge clk)
        if (bus.digit_valid) pulses++;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_pat(input logic [6:0] p);
        {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = p;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drives a digit pattern for 10 clocks; checks pulse latency and the decoded digit.
    task automatic step_digit(input logic [6:0] p, input int exp_d);
        int lat;
        lat = 0;
        set_pat(p);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.digit_valid && lat == 0) lat = k;
        end
        check_eq($sformatf("latency_d%0d", exp_d), lat, 6);
        check_eq($sformatf("digit_d%0d", exp_d), int'(bus.digit), exp_d);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_digit"}, int'(bus.digit), 0);
        check_eq({tag, "_valid"}, int'(bus.digit_valid), 0);
        check_eq({tag, "_blank"}, int'(bus.blank), 1);
        check_eq({tag, "_errp"}, int'(bus.err_pattern), 0);
        check_eq({tag, "_errs"}, int'(bus.err_sequence), 0);
        check_eq({tag, "_step"}, int'(bus.step_count), 0);
    endtask

    initial begin
        set_pat(PBL);
        hold(3);
        rst = 1'b0;
        check_reset_state("reset");
        hold(20);
        check_eq("idle_pulses", pulses, 0);
        check_eq("idle_blank", int'(bus.blank), 1);
        check_eq("idle_step", int'(bus.step_count), 0);

        step_digit(P0, 0); step_digit(P1, 1); step_digit(P2, 2);
        step_digit(P3, 3); step_digit(P4, 4); step_digit(P5, 5);
        step_digit(P6, 6); step_digit(P7, 7); step_digit(P0, 0);
        check_eq("seq_pulses", pulses, 9);
        check_eq("seq_step", int'(bus.step_count), 8);
        check_eq("seq_errs", int'(bus.err_sequence), 0);
        check_eq("seq_blank", int'(bus.blank), 0);

        step_digit(P1, 1); step_digit(P2, 2); step_digit(P3, 3);
        base = pulses;
        set_pat(P1);
        hold(2);
        set_pat(P3);
        hold(10);
        check_eq("glitch_pulses", pulses, base);
        check_eq("glitch_digit", int'(bus.digit), 3);
        check_eq("glitch_step", int'(bus.step_count), 11);

        step_digit(P0, 0); step_digit(P1, 1); step_digit(P2, 2);
        check_eq("pre_err_step", int'(bus.step_count), 14);
        step_digit(P5, 5);
        check_eq("jump_errs", int'(bus.err_sequence), 1);
        check_eq("jump_step", int'(bus.step_count), 14);
        step_digit(P6, 6);
        check_eq("after_jump_step", int'(bus.step_count), 15);
        check_eq("sticky_errs", int'(bus.err_sequence), 1);

        base = pulses;
        set_pat(PBAD);
        hold(10);
        check_eq("bad_errp", int'(bus.err_pattern), 1);
        check_eq("bad_pulses", pulses, base);
        check_eq("bad_digit", int'(bus.digit), 6);
        check_eq("bad_blank", int'(bus.blank), 0);
        step_digit(P4, 4);
        check_eq("rewait_step", int'(bus.step_count), 15);
        step_digit(P5, 5);
        check_eq("retrack_step", int'(bus.step_count), 16);

        base = pulses;
        set_pat(PBL);
        hold(10);
        check_eq("blank_blank", int'(bus.blank), 1);
        check_eq("blank_digit", int'(bus.digit), 5);
        check_eq("blank_pulses", pulses, base);
        step_digit(P3, 3);
        check_eq("after_blank_step", int'(bus.step_count), 16);
        check_eq("after_blank_blank", int'(bus.blank), 0);
        step_digit(P4, 4);
        check_eq("pre_over_step", int'(bus.step_count), 17);
        step_digit(P8, 8);
        check_eq("over_wrap_step", int'(bus.step_count), 17);
        check_eq("over_wrap_errs", int'(bus.err_sequence), 1);

        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");
        rst = 1'b0;
        hold(10);
        check_eq("post_reset_digit", int'(bus.digit), 8);
        check_eq("post_reset_step", int'(bus.step_count), 0);
        check_eq("post_reset_errs", int'(bus.err_sequence), 0);
        check_eq("post_reset_errp", int'(bus.err_pattern), 0);
        step_digit(P0, 0);
        check_eq("post_reset_seq_step", int'(bus.step_count), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
